scene_engine: RTL and testbench

- Single-clock game-scene core for the ROBO-ESCAPE display path.
- Raster-scans a pixel grid and emits one (x, y, colour) triple per clock, layering a fixed platform map and a character sprite over a background colour.
- A built-in tick divider paces character motion: walk, gravity and jump, with collision probes into the platform map.
- Output feeds the VGA adapter plot interface.

---
 rtl/scene_pkg.sv | 53 +++++
 rtl/scene_map_lookup.sv | 29 ++
 rtl/scene_engine.sv | 166 ++++++++++++++++
 tb/tb_scene_engine.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/scene_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scene_pkg
// Purpose  : Shared colours, sprite geometry, probe offsets and map rectangles
//            for the ROBO-ESCAPE scene core.
// Revision : 1.0
// ============================================================================
package scene_pkg;

    localparam logic [2:0] c_bg          = 3'b001;
    localparam logic [2:0] c_empty       = 3'b000;
    localparam logic [2:0] c_transparent = 3'b111;
    localparam logic [2:0] c_ground      = 3'b010;
    localparam logic [2:0] c_wall        = 3'b011;
    localparam logic [2:0] c_head        = 3'b110;
    localparam logic [2:0] c_body        = 3'b100;

    localparam int c_sprite_w  = 8;
    localparam int c_sprite_h  = 12;
    localparam int c_head_rows = 4;

    typedef enum logic [1:0] {
        PROBE_DOWN  = 2'd0,
        PROBE_RIGHT = 2'd1,
        PROBE_LEFT  = 2'd2,
        PROBE_UP    = 2'd3
    } probe_e;

    // Offsets are 9-bit two's complement so the probes wrap like the raster.
    localparam logic [8:0] c_probe_dx [4] = '{9'd4,  9'd11, 9'h1FC, 9'd4};
    localparam logic [8:0] c_probe_dy [4] = '{9'd12, 9'd4,  9'd4,   9'h1FA};

    typedef struct packed {
        logic [8:0] x0;
        logic [8:0] x1;
        logic [8:0] y0;
        logic [8:0] y1;
    } rect_t;

    localparam rect_t c_floor  = '{x0: 9'd0,   x1: 9'd511, y0: 9'd217, y1: 9'd239};
    localparam rect_t c_wall_l = '{x0: 9'd0,   x1: 9'd3,   y0: 9'd0,   y1: 9'd511};
    localparam rect_t c_wall_r = '{x0: 9'd316, x1: 9'd319, y0: 9'd0,   y1: 9'd511};
    localparam rect_t c_plat_a = '{x0: 9'd60,  x1: 9'd139, y0: 9'd180, y1: 9'd187};
    localparam rect_t c_plat_b = '{x0: 9'd160, x1: 9'd239, y0: 9'd140, y1: 9'd147};
    localparam rect_t c_plat_c = '{x0: 9'd40,  x1: 9'd119, y0: 9'd100, y1: 9'd107};

    function automatic logic in_rect(input logic [8:0] px, input logic [8:0] py,
                                     input rect_t r);
        return (px >= r.x0) && (px <= r.x1) && (py >= r.y0) && (py <= r.y1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/scene_map_lookup.sv
`default_nettype none
// ============================================================================
// Module   : scene_map_lookup
// Purpose  : Combinational platform-map colour for one (px, py) coordinate.
// Revision : 1.0
// ============================================================================
module scene_map_lookup
    import scene_pkg::*;
(
    input  logic [8:0] i_px,
    input  logic [8:0] i_py,
    output logic [2:0] o_colour
);

    // Floor wins over the walls where they overlap in the bottom rows.
    always_comb begin
        o_colour = c_empty;
        if (in_rect(i_px, i_py, c_floor)) begin
            o_colour = c_ground;
        end else if (in_rect(i_px, i_py, c_wall_l) || in_rect(i_px, i_py, c_wall_r)) begin
            o_colour = c_wall;
        end else if (in_rect(i_px, i_py, c_plat_a) || in_rect(i_px, i_py, c_plat_b) ||
                     in_rect(i_px, i_py, c_plat_c)) begin
            o_colour = c_ground;
        end
    end

endmodule
`default_nettype wire

// File: rtl/scene_engine.sv
`default_nettype none
// ============================================================================
// Module   : scene_engine
// Purpose  : Raster scan with map/sprite layering and tick-paced character
//            motion (walk, gravity, jump) for the VGA plot interface.
// Revision : 1.0
// ============================================================================
module scene_engine
    import scene_pkg::*;
#(
    parameter int DIV     = 60,
    parameter int JUMP_H  = 40,
    parameter int START_X = 35,
    parameter int START_Y = 205
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [8:0] max_x,
    input  logic [8:0] max_y,
    input  logic [3:0] key,
    output logic [8:0] x_out,
    output logic [8:0] y_out,
    output logic [2:0] colour_out
);

    localparam int         c_cnt_w  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [8:0] c_jump_h = 9'(JUMP_H);

    logic [8:0]         r_x;
    logic [8:0]         r_y;
    logic [2:0]         r_colour;
    logic [8:0]         r_cx;
    logic [8:0]         r_cy;
    logic               r_jumping;
    logic [8:0]         r_max_jump;
    logic [c_cnt_w-1:0] r_tick_cnt;

    logic               w_tick;
    logic [8:0]         w_x_nxt;
    logic [8:0]         w_y_inc;
    logic [8:0]         w_y_nxt;
    logic [9:0]         w_dx;
    logic [9:0]         w_dy;
    logic [2:0]         w_sprite;
    logic [2:0]         w_map;
    logic [2:0]         w_pix_colour;
    logic [8:0]         w_probe_x [4];
    logic [8:0]         w_probe_y [4];
    logic [2:0]         w_probe_c [4];
    logic               w_down_empty;
    logic               w_right_empty;
    logic               w_left_empty;
    logic               w_up_empty;
    logic [8:0]         w_cx_nxt;
    logic [8:0]         w_cy_nxt;
    logic               w_jump_nxt;
    logic [8:0]         w_max_jump_nxt;
    logic               w_unused;

    assign w_unused = key[1];
    assign w_tick   = (r_tick_cnt == c_cnt_w'(DIV - 1));

    // Raster advance; the colour is computed for the coordinate being emitted next.
    assign w_x_nxt = (r_x == max_x) ? 9'd0 : r_x + 9'd1;
    assign w_y_inc = (r_x == max_x) ? r_y + 9'd1 : r_y;
    assign w_y_nxt = (w_y_inc == max_y) ? 9'd0 : w_y_inc;

    // Widened subtraction so pixels left of / above the sprite fall outside the box.
    assign w_dx = {1'b0, w_x_nxt} - {1'b0, r_cx};
    assign w_dy = {1'b0, w_y_nxt} - {1'b0, r_cy};

    always_comb begin
        w_sprite = c_transparent;
        if ((w_dx < 10'(c_sprite_w)) && (w_dy < 10'(c_sprite_h))) begin
            w_sprite = (w_dy < 10'(c_head_rows)) ? c_head : c_body;
        end
    end

    scene_map_lookup u_scan_map (
        .i_px     (w_x_nxt),
        .i_py     (w_y_nxt),
        .o_colour (w_map)
    );

    always_comb begin
        w_pix_colour = c_bg;
        if (w_sprite != c_transparent) begin
            w_pix_colour = w_sprite;
        end else if (w_map != c_empty) begin
            w_pix_colour = w_map;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_probe
        assign w_probe_x[gi] = r_cx + c_probe_dx[gi];
        assign w_probe_y[gi] = r_cy + c_probe_dy[gi];
        scene_map_lookup u_probe_map (
            .i_px     (w_probe_x[gi]),
            .i_py     (w_probe_y[gi]),
            .o_colour (w_probe_c[gi])
        );
    end

    assign w_down_empty  = (w_probe_c[PROBE_DOWN]  == c_empty);
    assign w_right_empty = (w_probe_c[PROBE_RIGHT] == c_empty);
    assign w_left_empty  = (w_probe_c[PROBE_LEFT]  == c_empty);
    assign w_up_empty    = (w_probe_c[PROBE_UP]    == c_empty);

    // Steps chain: each one sees the position/jump state left by the previous one,
    // while all probes stay anchored at the pre-tick position.
    always_comb begin
        w_cx_nxt       = r_cx;
        w_cy_nxt       = r_cy;
        w_jump_nxt     = r_jumping;
        w_max_jump_nxt = r_max_jump;
        if (key[3] && w_right_empty) begin
            w_cx_nxt = w_cx_nxt + 9'd1;
        end
        if (key[2] && w_left_empty) begin
            w_cx_nxt = w_cx_nxt - 9'd1;
        end
        if (w_down_empty && !w_jump_nxt) begin
            w_cy_nxt = w_cy_nxt + 9'd1;
        end
        if (!key[0] && !w_jump_nxt && !w_down_empty) begin
            w_jump_nxt     = 1'b1;
            w_max_jump_nxt = w_cy_nxt - c_jump_h;
        end
        if (w_jump_nxt && w_up_empty) begin
            w_cy_nxt = w_cy_nxt - 9'd1;
        end
        if (w_jump_nxt && ((w_cy_nxt == w_max_jump_nxt) || !w_up_empty)) begin
            w_jump_nxt = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_x        <= 9'd0;
            r_y        <= 9'd0;
            r_colour   <= c_bg;
            r_cx       <= 9'(START_X);
            r_cy       <= 9'(START_Y);
            r_jumping  <= 1'b0;
            r_max_jump <= 9'd0;
            r_tick_cnt <= '0;
        end else begin
            r_x        <= w_x_nxt;
            r_y        <= w_y_nxt;
            r_colour   <= w_pix_colour;
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + c_cnt_w'(1);
            if (w_tick) begin
                r_cx       <= w_cx_nxt;
                r_cy       <= w_cy_nxt;
                r_jumping  <= w_jump_nxt;
                r_max_jump <= w_max_jump_nxt;
            end
        end
    end

    assign x_out      = r_x;
    assign y_out      = r_y;
    assign colour_out = r_colour;

endmodule
`default_nettype wire

// File: tb/tb_scene_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_scene_engine
// Purpose  : Scoreboard bench for scene_engine: raster, layering, motion.
// Revision : 1.0
// ============================================================================
module tb_scene_engine;

    localparam int DIV = 4;

    logic       clock  = 1'b0;
    logic       resetn = 1'b0;
    logic [8:0] max_x  = 9'd319;
    logic [8:0] max_y  = 9'd240;
    logic [3:0] key    = 4'b0011;
    logic [8:0] x_out;
    logic [8:0] y_out;
    logic [2:0] colour_out;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic       is_pos;
        logic [8:0] a;
        logic [8:0] b;
        logic [2:0] c;
    } exp_t;

    exp_t  exp_q  [$];
    string name_q [$];

    bit scan_skip = 1'b1;
    bit have_prev = 1'b0;
    int prev_x, prev_y, scan_prints;

    // x, y, colour in scan order; the final (1,0) entry only matches in the next frame.
    int pix_tab [23][3] = '{
        '{315,   0, 1}, '{316,   0, 3}, '{  2,   5, 3}, '{200,  50, 1},
        '{ 40, 100, 2}, '{319, 100, 3}, '{119, 107, 2}, '{120, 107, 1},
        '{160, 140, 2}, '{ 60, 180, 2}, '{139, 187, 2}, '{140, 187, 1},
        '{ 35, 205, 6}, '{ 42, 208, 6}, '{ 38, 209, 4}, '{ 34, 210, 1},
        '{ 43, 210, 1}, '{ 42, 216, 4}, '{ 35, 217, 2}, '{100, 218, 2},
        '{  0, 220, 2}, '{  3, 239, 2}, '{  1,   0, 3}
    };

    scene_engine #(.DIV(DIV), .JUMP_H(40), .START_X(35), .START_Y(205)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .max_x      (max_x),
        .max_y      (max_y),
        .key        (key),
        .x_out      (x_out),
        .y_out      (y_out),
        .colour_out (colour_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Scoreboard monitor: position entries compare on the next negedge,
    // pixel entries when the DUT emits the matching coordinate.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            if (exp_q[0].is_pos) begin
                check({name_q[0], " cx"}, int'(dut.r_cx), int'(exp_q[0].a));
                check({name_q[0], " cy"}, int'(dut.r_cy), int'(exp_q[0].b));
                check({name_q[0], " jumping"}, int'(dut.r_jumping), int'(exp_q[0].c));
                void'(exp_q.pop_front());
                void'(name_q.pop_front());
            end else if (x_out == exp_q[0].a && y_out == exp_q[0].b) begin
                check(name_q[0], int'(colour_out), int'(exp_q[0].c));
                void'(exp_q.pop_front());
                void'(name_q.pop_front());
            end
        end
    end

    // Raster continuity against a 320x240 scan.
    always @(negedge clock) begin
        if (scan_skip) begin
            have_prev = 1'b0;
        end else begin
            if (have_prev) begin
                int ex, ey;
                ex = (prev_x == 319) ? 0 : prev_x + 1;
                ey = (prev_x == 319) ? ((prev_y == 239) ? 0 : prev_y + 1) : prev_y;
                n_cmp++;
                if (int'(x_out) != ex || int'(y_out) != ey) begin
                    n_fail++;
                    if (scan_prints < 10) begin
                        scan_prints++;
                        $display("FAIL scan step: got (%0d,%0d), required (%0d,%0d)",
                                 x_out, y_out, ex, ey);
                    end
                end
            end
            prev_x    = int'(x_out);
            prev_y    = int'(y_out);
            have_prev = 1'b1;
        end
    end

    task automatic drain(input int bound);
        int n = 0;
        while (exp_q.size() > 0 && n < bound) begin
            @(negedge clock);
            #1;
            n++;
        end
        while (exp_q.size() > 0) begin
            check({"timeout ", name_q[0]}, 0, 1);
            void'(exp_q.pop_front());
            void'(name_q.pop_front());
        end
    endtask

    task automatic expect_pix(input string name, input int x, input int y, input int c);
        exp_t e;
        e.is_pos = 1'b0;
        e.a = 9'(x);
        e.b = 9'(y);
        e.c = 3'(c);
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    task automatic expect_pos(input string name, input int cx, input int cy, input int jmp);
        exp_t e;
        e.is_pos = 1'b1;
        e.a = 9'(cx);
        e.b = 9'(cy);
        e.c = 3'(jmp);
        exp_q.push_back(e);
        name_q.push_back(name);
        drain(8);
    endtask

    // Returns one time unit after the n-th tick edge.
    task automatic wait_ticks(input int n);
        repeat (n) begin
            int g = 0;
            while (!dut.w_tick && g < 2 * DIV + 2) begin
                @(posedge clock);
                #1;
                g++;
            end
            if (!dut.w_tick) check("tick wait", 0, 1);
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " x_out"}, int'(x_out), 0);
        check({tag, " y_out"}, int'(y_out), 0);
        check({tag, " colour_out"}, int'(colour_out), 1);
        check({tag, " cx"}, int'(dut.r_cx), 35);
        check({tag, " cy"}, int'(dut.r_cy), 205);
        check({tag, " jumping"}, int'(dut.r_jumping), 0);
        check({tag, " tick count"}, int'(dut.r_tick_cnt), 0);
    endtask

    initial begin
        int prev, n;
        repeat (3) @(posedge clock);
        #1;
        check_reset_state("reset");

        for (int i = 0; i < 23; i++) begin
            expect_pix($sformatf("pixel(%0d,%0d)", pix_tab[i][0], pix_tab[i][1]),
                       pix_tab[i][0], pix_tab[i][1], pix_tab[i][2]);
        end
        resetn    = 1'b1;
        scan_skip = 1'b0;
        drain(80000);
        expect_pos("idle frame", 35, 205, 0);

        key = 4'b1001;
        wait_ticks(10);
        expect_pos("right 10", 45, 205, 0);
        wait_ticks(270);
        expect_pos("right wall", 305, 205, 0);

        key = 4'b0101;
        wait_ticks(1);
        check("left step cx", int'(dut.r_cx), 304);
        prev = int'(dut.r_cx);
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (int'(dut.r_cx) == prev && n < 20);
        check("tick spacing", n, DIV);
        check("spacing cx", int'(dut.r_cx), 303);

        key = 4'b1001;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        check("between ticks cx", int'(dut.r_cx), 303);
        key = 4'b0101;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        check("after key swap cx", int'(dut.r_cx), 302);

        key = 4'b0000;
        wait_ticks(1);
        key = 4'b0001;
        expect_pos("jump start", 302, 204, 1);
        wait_ticks(39);
        expect_pos("jump apex", 302, 165, 0);
        wait_ticks(20);
        expect_pos("falling", 302, 185, 0);
        wait_ticks(20);
        expect_pos("landed", 302, 205, 0);
        wait_ticks(10);
        expect_pos("grounded", 302, 205, 0);

        key = 4'b0000;
        wait_ticks(81);
        expect_pos("retrigger", 302, 204, 1);
        wait_ticks(5);
        expect_pos("mid jump", 302, 199, 1);

        scan_skip = 1'b1;
        key    = 4'b0011;
        resetn = 1'b0;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        check_reset_state("mid reset");
        resetn    = 1'b1;
        scan_skip = 1'b0;
        repeat (20) @(posedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
